// File: rtl/avg_pool_scheduler.sv
// Average-pool window scheduler: walks every window of a square float16 map, feeds the pool unit
// one element per cycle and writes each result. Optional perf counter: define AVG_POOL_SCHED_PERF_EN.
module avg_pool_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_WIDTH-1:0]   fm_size,
  input  logic [DIM_WIDTH-1:0]   kernel_size,
  input  logic [DIM_WIDTH-1:0]   stride,
  input  logic [ADDR_WIDTH-1:0]  in_base,
  input  logic [ADDR_WIDTH-1:0]  out_base,
  output logic                   in_rd_en,
  output logic [ADDR_WIDTH-1:0]  in_rd_addr,
  input  logic [DATA_WIDTH-1:0]  in_rd_data,
  output logic                   pool_rst,
  output logic [DATA_WIDTH-1:0]  pool_data,
  output logic [2*DIM_WIDTH-1:0] pool_data_num,
  input  logic                   pool_ready,
  input  logic [DATA_WIDTH-1:0]  pool_result,
  output logic                   out_wr_en,
  output logic [ADDR_WIDTH-1:0]  out_wr_addr,
  output logic [DATA_WIDTH-1:0]  out_wr_data,
  output logic                   busy,
  output logic                   done,
`ifdef AVG_POOL_SCHED_PERF_EN
  output logic                   cfg_err,
  output logic [31:0]            perf_cycles
`else
  output logic                   cfg_err
`endif
);

  localparam int PW = 2*DIM_WIDTH;
  localparam int CW = 2*DIM_WIDTH + 1;
  localparam int EW = DIM_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t state;

  logic [DIM_WIDTH-1:0]  f_q, k_q, s_q;
  logic [DIM_WIDTH-1:0]  kx, ky, cx, ry;
  logic [PW-1:0]         n_q;
  logic [ADDR_WIDTH-1:0] out_base_q, row_step_q, row_addr, win_row_addr;
  logic [CW-1:0]         slot, win_cnt, res_idx;
  logic                  rd_en, rd_vld, issued_all;

  logic                  cfg_bad, col_more, row_more, kx_last, ky_last, rd_run, rd_first;
  logic [PW-1:0]         sf_prod, kk_prod;
  logic [EW-1:0]         col_end, row_end;
  logic [DIM_WIDTH-1:0]  k_last;
  logic [CW-1:0]         n_ext, period_end, slot_nxt;

  assign cfg_bad  = (kernel_size == '0) || (stride == '0) || (kernel_size > fm_size);
  assign sf_prod  = PW'(stride) * PW'(fm_size);
  assign kk_prod  = PW'(kernel_size) * PW'(kernel_size);

  // Next window fits horizontally / vertically iff base+S+K <= F.
  assign col_end  = EW'(cx) + EW'(s_q) + EW'(k_q);
  assign row_end  = EW'(ry) + EW'(s_q) + EW'(k_q);
  assign col_more = col_end <= EW'(f_q);
  assign row_more = row_end <= EW'(f_q);
  assign k_last   = k_q - DIM_WIDTH'(1);
  assign kx_last  = kx == k_last;
  assign ky_last  = ky == k_last;

  // Reads land in slots 0..N-2 (elements 1..N-1) and slot N+2 (next window's element 0).
  assign n_ext      = CW'(n_q);
  assign period_end = n_ext + CW'(2);
  assign slot_nxt   = (slot == period_end) ? '0 : slot + CW'(1);
  assign rd_run     = (slot_nxt + CW'(1) < n_ext) || ((slot_nxt == period_end) && !issued_all);
  assign rd_first   = n_ext > CW'(1);

  assign in_rd_en      = rd_en;
  assign in_rd_addr    = rd_en ? (row_addr + ADDR_WIDTH'(cx) + ADDR_WIDTH'(kx)) : '0;
  assign pool_data     = rd_vld ? in_rd_data : '0;
  assign pool_data_num = n_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      f_q          <= '0;
      k_q          <= '0;
      s_q          <= '0;
      n_q          <= '0;
      kx           <= '0;
      ky           <= '0;
      cx           <= '0;
      ry           <= '0;
      out_base_q   <= '0;
      row_step_q   <= '0;
      row_addr     <= '0;
      win_row_addr <= '0;
      slot         <= '0;
      win_cnt      <= '0;
      res_idx      <= '0;
      rd_en        <= 1'b0;
      rd_vld       <= 1'b0;
      issued_all   <= 1'b0;
      pool_rst     <= 1'b0;
      out_wr_en    <= 1'b0;
      out_wr_addr  <= '0;
      out_wr_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      out_wr_en <= 1'b0;
      done      <= 1'b0;
      rd_vld    <= rd_en;

      if (pool_ready && busy) begin
        out_wr_en   <= 1'b1;
        out_wr_data <= pool_result;
        out_wr_addr <= out_base_q + ADDR_WIDTH'(res_idx);
        res_idx     <= res_idx + CW'(1);
      end

      // Read pointer: kx fastest, then ky, then window column, then window row.
      if (rd_en) begin
        if (!kx_last) begin
          kx <= kx + DIM_WIDTH'(1);
        end else begin
          kx <= '0;
          if (!ky_last) begin
            ky       <= ky + DIM_WIDTH'(1);
            row_addr <= row_addr + ADDR_WIDTH'(f_q);
          end else begin
            ky      <= '0;
            win_cnt <= win_cnt + CW'(1);
            if (col_more) begin
              cx       <= cx + s_q;
              row_addr <= win_row_addr;
            end else if (row_more) begin
              cx           <= '0;
              ry           <= ry + s_q;
              win_row_addr <= win_row_addr + row_step_q;
              row_addr     <= win_row_addr + row_step_q;
            end else begin
              issued_all <= 1'b1;
            end
          end
        end
      end

      case (state)
        IDLE: begin
          pool_rst <= 1'b0;
          busy     <= 1'b0;
          if (start && !busy) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              f_q          <= fm_size;
              k_q          <= kernel_size;
              s_q          <= stride;
              n_q          <= kk_prod;
              row_step_q   <= ADDR_WIDTH'(sf_prod);
              out_base_q   <= out_base;
              row_addr     <= in_base;
              win_row_addr <= in_base;
              kx           <= '0;
              ky           <= '0;
              cx           <= '0;
              ry           <= '0;
              slot         <= '0;
              win_cnt      <= '0;
              res_idx      <= '0;
              issued_all   <= 1'b0;
              cfg_err      <= 1'b0;
              busy         <= 1'b1;
              rd_en        <= 1'b1;
              state        <= PRIME;
            end
          end
        end
        PRIME: begin
          state    <= RUN;
          pool_rst <= 1'b1;
          slot     <= '0;
          rd_en    <= rd_first;
        end
        RUN: begin
          slot  <= slot_nxt;
          rd_en <= rd_run;
          if (issued_all && (slot == n_ext - CW'(1))) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          // Done coincides with the last write; the second term covers results that beat DRAIN.
          if ((pool_ready && (res_idx + CW'(1) == win_cnt)) || (res_idx == win_cnt)) begin
            done     <= 1'b1;
            state    <= IDLE;
            pool_rst <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AVG_POOL_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_cycles <= '0;
    else if ((state == IDLE) && start && !busy && !cfg_bad)
      perf_cycles <= '0;
    else if (busy)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_avg_pool_scheduler.sv
// Scoreboard bench for avg_pool_scheduler: buffer + float16 pool-unit models, directed layers.
module tb_avg_pool_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  fm_size = '0, kernel_size = '0, stride = '0;
  logic [15:0] in_base = '0, out_base = '0;
  logic        in_rd_en;
  logic [15:0] in_rd_addr;
  logic [15:0] in_rd_data = '0;
  logic        pool_rst;
  logic [15:0] pool_data;
  logic [15:0] pool_data_num;
  logic        pool_ready = 1'b0;
  logic [15:0] pool_result = '0;
  logic        out_wr_en;
  logic [15:0] out_wr_addr, out_wr_data;
  logic        busy, done, cfg_err;

  avg_pool_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .fm_size(fm_size), .kernel_size(kernel_size),
    .stride(stride), .in_base(in_base), .out_base(out_base), .in_rd_en(in_rd_en),
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data), .pool_rst(pool_rst),
    .pool_data(pool_data), .pool_data_num(pool_data_num), .pool_ready(pool_ready),
    .pool_result(pool_result), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  bit          rd_chk = 0;
  logic [15:0] mem [0:1023];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic real h2r(input logic [15:0] h);
    real m; int e;
    if (h[14:10] == 5'd0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real m; int e, mant; logic [4:0] ef; logic [9:0] mf;
    if (v <= 0.0) return 16'h0;
    m = v; e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    mant = $rtoi((m - 1.0) * 1024.0 + 0.5);
    ef = 5'(e + 15);
    mf = 10'(mant);
    return {1'b0, ef, mf};
  endfunction

  // Input buffer: 1-cycle read latency.
  always @(posedge clk) if (in_rd_en) in_rd_data <= mem[in_rd_addr[9:0]];

  // Pool unit: N data slots then 3 idle slots; result valid in the last idle slot.
  int  pc = 0, pn;
  real acc = 0.0;
  always @(posedge clk) begin
    pn = int'(pool_data_num);
    if (!pool_rst) begin
      pc = 0; acc = 0.0; pool_ready <= 1'b0;
    end else begin
      if (pc < pn) acc = acc + h2r(pool_data);
      pool_ready <= (pc == pn + 1);
      if (pc == pn + 1) pool_result <= r2h(acc / real'(pn));
      if (pc == pn + 2) begin pc = 0; acc = 0.0; end
      else pc++;
    end
  end

  // Monitor: pops expected writes/reads as the DUT presents them.
  always @(negedge clk) begin
    wr_t e;
    if (out_wr_en) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", out_wr_addr, out_wr_data);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", out_wr_addr, e.addr);
        chk("wr_data", out_wr_data, e.data);
      end
    end
    if (in_rd_en) begin
      rd_cnt++;
      if (rd_chk) begin
        if (rd_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_read: addr %0h, none expected", in_rd_addr);
        end else chk("rd_addr", in_rd_addr, rd_q.pop_front());
      end
    end
    if (done) done_cnt++;
  end

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t e; e.addr = a; e.data = d; wr_q.push_back(e);
  endtask

  task automatic kick(input logic [7:0] f, input logic [7:0] k, input logic [7:0] s,
                      input logic [15:0] ib, input logic [15:0] ob);
    @(negedge clk);
    fm_size = f; kernel_size = k; stride = s; in_base = ib; out_base = ob; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer(input string nm, input int nwr, input int w0, input int d0, input int tmo);
    bit seen = 0;
    for (int i = 0; i < tmo && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_busy_after"}, busy, 1'b0);
    chk({nm, "_wr_count"}, wr_cnt - wr_q.size() * 0 - w0, nwr);
    chk({nm, "_wr_pending"}, wr_q.size(), 0);
  endtask

  task automatic fill_ramp(input int base, input int n);
    for (int i = 0; i < n; i++) mem[base + i] = r2h(real'(i + 1));
  endtask

  initial begin
    int w0, d0, r0;
    logic [15:0] t3_rd [16];
    t3_rd = '{16'h20, 16'h21, 16'h25, 16'h26, 16'h22, 16'h23, 16'h27, 16'h28,
              16'h2A, 16'h2B, 16'h2F, 16'h30, 16'h2C, 16'h2D, 16'h31, 16'h32};
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {in_rd_en, in_rd_addr, pool_rst, pool_data, pool_data_num, out_wr_en,
                       out_wr_addr, out_wr_data, busy, done, cfg_err}, '0);
    rst = 1'b1;
    @(negedge clk);

    // F=4 K=2 S=2, ramp 1..16
    fill_ramp(0, 16);
    push_wr(16'h100, 16'h4300); push_wr(16'h101, 16'h4580);
    push_wr(16'h102, 16'h49C0); push_wr(16'h103, 16'h4AC0);
    w0 = wr_cnt; d0 = done_cnt;
    kick(8'd4, 8'd2, 8'd2, 16'h0, 16'h100);
    run_layer("f4k2s2", 4, w0, d0, 400);

    // Illegal configs
    w0 = wr_cnt; d0 = done_cnt; r0 = rd_cnt;
    kick(8'd5, 8'd0, 8'd1, 16'h0, 16'h400);
    repeat (2) @(negedge clk);
    chk("k0_cfg_err", cfg_err, 1'b1);
    chk("k0_busy", busy, 1'b0);
    kick(8'd5, 8'd6, 8'd1, 16'h0, 16'h400);
    repeat (2) @(negedge clk);
    chk("k_gt_f_cfg_err", cfg_err, 1'b1);
    chk("k_gt_f_busy", busy, 1'b0);
    kick(8'd5, 8'd2, 8'd0, 16'h0, 16'h400);
    repeat (2) @(negedge clk);
    chk("s0_cfg_err", cfg_err, 1'b1);
    chk("illegal_reads", rd_cnt - r0, 0);
    chk("illegal_writes", wr_cnt - w0, 0);
    chk("illegal_done", done_cnt - d0, 0);

    // F=3 K=3 S=1, all 2.0; legal start clears cfg_err
    for (int i = 0; i < 9; i++) begin mem[i] = 16'h4000; rd_q.push_back(16'(i)); end
    rd_chk = 1;
    push_wr(16'h180, 16'h4000);
    w0 = wr_cnt; d0 = done_cnt;
    kick(8'd3, 8'd3, 8'd1, 16'h0, 16'h180);
    @(negedge clk);
    chk("legal_clears_cfg_err", cfg_err, 1'b0);
    chk("pool_data_num_9", pool_data_num, 16'd9);
    run_layer("f3k3s1", 1, w0, d0, 400);
    chk("f3k3_rd_pending", rd_q.size(), 0);

    // F=5 K=2 S=2 at in_base 0x20
    fill_ramp(16'h20, 25);
    for (int i = 0; i < 16; i++) rd_q.push_back(t3_rd[i]);
    push_wr(16'h200, 16'h4400); push_wr(16'h201, 16'h4600);
    push_wr(16'h202, 16'h4B00); push_wr(16'h203, 16'h4C00);
    w0 = wr_cnt; d0 = done_cnt;
    kick(8'd5, 8'd2, 8'd2, 16'h20, 16'h200);
    run_layer("f5k2s2", 4, w0, d0, 400);
    chk("f5k2_rd_pending", rd_q.size(), 0);
    rd_chk = 0;

    // K=1: 4-cycle period, write overlaps final data slot
    mem[16'h40] = 16'h3C00; mem[16'h41] = 16'h4000; mem[16'h42] = 16'h4200; mem[16'h43] = 16'h4400;
    push_wr(16'h300, 16'h3C00); push_wr(16'h301, 16'h4000);
    push_wr(16'h302, 16'h4200); push_wr(16'h303, 16'h4400);
    w0 = wr_cnt; d0 = done_cnt;
    kick(8'd2, 8'd1, 8'd1, 16'h40, 16'h300);
    run_layer("f2k1s1", 4, w0, d0, 200);

    // Reset mid-RUN, then a clean rerun
    fill_ramp(0, 16);
    d0 = done_cnt;
    kick(8'd4, 8'd2, 8'd1, 16'h0, 16'h280);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun_reset_outs", {in_rd_en, in_rd_addr, pool_rst, pool_data, pool_data_num, out_wr_en,
                              out_wr_addr, out_wr_data, busy, done, cfg_err}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    push_wr(16'h280, 16'h4300); push_wr(16'h281, 16'h4480); push_wr(16'h282, 16'h4580);
    push_wr(16'h283, 16'h4780); push_wr(16'h284, 16'h4840); push_wr(16'h285, 16'h48C0);
    push_wr(16'h286, 16'h49C0); push_wr(16'h287, 16'h4A40); push_wr(16'h288, 16'h4AC0);
    w0 = wr_cnt; d0 = done_cnt;
    kick(8'd4, 8'd2, 8'd1, 16'h0, 16'h280);
    run_layer("f4k2s1", 9, w0, d0, 800);

    // Second start mid-layer is ignored
    fill_ramp(0, 16);
    push_wr(16'h100, 16'h4300); push_wr(16'h101, 16'h4580);
    push_wr(16'h102, 16'h49C0); push_wr(16'h103, 16'h4AC0);
    w0 = wr_cnt; d0 = done_cnt;
    kick(8'd4, 8'd2, 8'd2, 16'h0, 16'h100);
    repeat (5) @(negedge clk);
    kick(8'd5, 8'd3, 8'd1, 16'h20, 16'h500);
    chk("restart_num_kept", pool_data_num, 16'd4);
    chk("restart_no_cfg_err", cfg_err, 1'b0);
    run_layer("restart", 4, w0, d0, 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avg_pool_scheduler.md
Name: avg_pool_scheduler

Overview:
- Sequences one float16 average-pool unit over a square input feature map held in an on-chip buffer. Walks every pooling window, streams the window's elements into the pool unit one per cycle, and writes each averaged result to an output buffer.
- Sits between the layer controller (start/config/done) and the pool datapath plus its input/output buffers.

Parameters:
- DATA_WIDTH, 16, element width (IEEE half).
- ADDR_WIDTH, 16, buffer address width.
- DIM_WIDTH, 8, width of size/kernel/stride fields.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches config and begins a layer.
- fm_size  in  DIM_WIDTH  input map width = height (F).
- kernel_size  in  DIM_WIDTH  window width = height (K).
- stride  in  DIM_WIDTH  window step (S).
- in_base  in  ADDR_WIDTH  input buffer base address.
- out_base  in  ADDR_WIDTH  output buffer base address.
- in_rd_en  out  1  input buffer read strobe.
- in_rd_addr  out  ADDR_WIDTH  input buffer read address.
- in_rd_data  in  DATA_WIDTH  input buffer data, valid 1 cycle after in_rd_en.
- pool_rst  out  1  active-low reset to the pool unit.
- pool_data  out  DATA_WIDTH  element fed to the pool unit.
- pool_data_num  out  DIM_WIDTH*2  elements per window (K*K).
- pool_ready  in  1  pool unit result-valid pulse.
- pool_result  in  DATA_WIDTH  pool unit average.
- out_wr_en  out  1  output buffer write strobe.
- out_wr_addr  out  ADDR_WIDTH  output write address.
- out_wr_data  out  DATA_WIDTH  output write data.
- busy  out  1  layer in progress.
- done  out  1  one-cycle pulse when the last result is written.
- cfg_err  out  1  sticky; set on illegal config, cleared by the next accepted start.

Behaviour:
- Reset values:
  - All outputs 0, except pool_rst, which is 0 (pool unit held in reset).
  - FSM returns to IDLE from any state, including mid-layer.
  - Partially issued windows are discarded; no done pulse.
- Config checks at start:
  - Output size O = floor((F-K)/S)+1; N = K*K; total windows W = O*O.
  - Illegal if K==0, S==0 or K>F. In that case cfg_err=1, stay IDLE, no done.
- start while busy=1 is ignored; config is not re-latched.
- FSM states:
  - IDLE: pool_rst=0. On a legal start: latch config, go to PRIME.
  - PRIME: one cycle. Issue the read of window 0, element 0. Go to RUN.
  - RUN:
    - pool_rst=1. Each pool-unit period is N+3 cycles: N data slots, then 3 idle slots.
    - In data slot k, pool_data = in_rd_data for element k; in idle slots pool_data = 0.
    - A read is issued one cycle before each data slot (1-cycle buffer latency).
    - After window W-1's data is issued, go to DRAIN.
  - DRAIN: no reads issued. Wait until W results have been written, then pulse done for 1 cycle and go to IDLE.
- Element order: row-major within the window (kx fastest). Windows are row-major (ox fastest).
- Read address = in_base + (oy*S+ky)*F + (ox*S+kx). Generate it with incrementing row/column offset registers, not multipliers.
- Result path:
  - Every pool_ready pulse while busy: out_wr_en=1 next cycle, out_wr_data=pool_result, out_wr_addr=out_base+result_index. result_index then increments.
  - pool_ready while not busy is ignored.
- busy=1 from the cycle after an accepted start through the cycle of done.
- Overlap: the final data slot and the write of the previous window's result may occur in the same cycle; both proceed.
- Edge case K==F: W=1. Edge case N==1: the period is 4 cycles.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no overflow detection.

Optional Feature:
- Macro AVG_POOL_SCHED_PERF_EN.
- Defined: adds output perf_cycles (32 bits). It is cleared on an accepted start, increments every cycle while busy, and holds its value after done until the next start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- F=4, K=2, S=2, in buffer = 1.0..16.0, in_base=0, out_base=0x100 -> writes 3.5, 5.5, 11.5, 13.5 to 0x100..0x103. done 1 pulse; busy low after done.
- F=3, K=3, S=1, all elements 2.0 -> exactly one write of 2.0 at out_base. pool_data_num=9; read addresses 0..8 in order.
- F=5, K=2, S=2 -> O=2, 4 writes. Window 1 read addresses are 2, 3, 7, 8 (offset by in_base).
- K=0, or K=6 with F=5 -> cfg_err=1, no reads, no writes, busy stays 0. Then a legal start clears cfg_err.
- Drive rst low during RUN of F=4, K=2, S=1 -> all outputs return to reset values and pool_rst=0. A fresh start then produces the full 9 correct writes.
- A second start pulse mid-layer -> ignored; the write count and addresses match the single-start run.
